// File: rtl/program_loader.sv
// program_loader: turns a valid/ready byte stream into little-endian
// instruction words, writes them to program memory from address 0 upward,
// and holds the CPU core in reset until the load has settled.
module program_loader #(
  parameter int WIDTH       = 32,
  parameter int ADD_WIDTH   = 8,
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [ADD_WIDTH:0]   load_len,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done
);

  localparam int BYTES  = WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_HOLD} state_t;

  state_t                r_state, w_next;
  logic [ADD_WIDTH:0]    r_len;
  logic [ADD_WIDTH:0]    r_cnt;
  logic [ADD_WIDTH-1:0]  r_add;
  logic [BIDX_W-1:0]     r_bidx;
  logic [WIDTH-1:0]      r_asm;
  logic [3:0]            r_hold;
  logic                  r_mem_wen;
  logic [ADD_WIDTH-1:0]  r_mem_add;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic                  r_cpu_rst;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_start;
  logic                  w_xfer;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_hold_done;
  logic [WIDTH-1:0]      w_asm_next;

  assign w_start     = (r_state == S_IDLE) && load_start;
  assign w_xfer      = (r_state == S_RECV) && byte_valid;
  assign w_last_byte = w_xfer && (r_bidx == BIDX_W'(BYTES - 1));
  assign w_last_word = ((r_cnt + (ADD_WIDTH+1)'(1)) == r_len);
  assign w_hold_done = (r_hold == 4'(HOLD_CYCLES - 1));

  // Drop the incoming byte into its lane of the assembly word (byte 0 = LSB)
  always_comb begin
    w_asm_next = r_asm;
    for (int i = 0; i < BYTES; i++)
      if (r_bidx == BIDX_W'(i)) w_asm_next[8*i +: 8] = byte_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load_start)  w_next = S_RECV;
      S_RECV:  if (w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_HOLD : S_RECV;
      S_HOLD:  if (w_hold_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; status flags follow the next state so
  // they change on the same edge as the state itself
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_add       <= '0;
      r_bidx      <= '0;
      r_asm       <= '0;
      r_hold      <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_add   <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cpu_rst <= (w_next == S_IDLE);
      r_busy    <= (w_next != S_IDLE);
      r_mem_wen <= (w_next == S_WRITE);

      if (w_start) begin
        r_len  <= (load_len == '0) ? (ADD_WIDTH+1)'(DEPTH) : load_len;
        r_cnt  <= '0;
        r_add  <= '0;
        r_bidx <= '0;
        r_asm  <= '0;
        r_done <= 1'b0;
      end

      if (w_xfer) begin
        r_asm  <= w_asm_next;
        r_bidx <= w_last_byte ? '0 : r_bidx + BIDX_W'(1);
        if (w_last_byte) begin
          r_mem_add   <= r_add;
          r_mem_wdata <= w_asm_next;
        end
      end

      // Address only advances when another word follows, so a full-depth
      // load stops at DEPTH-1 instead of wrapping
      if (r_state == S_WRITE) begin
        r_cnt  <= r_cnt + (ADD_WIDTH+1)'(1);
        r_bidx <= '0;
        if (!w_last_word) r_add <= r_add + ADD_WIDTH'(1);
      end

      if (r_state == S_WRITE)     r_hold <= '0;
      else if (r_state == S_HOLD) r_hold <= r_hold + 4'd1;

      if (r_state == S_HOLD && w_hold_done) r_done <= 1'b1;
    end
  end

  assign byte_ready = (r_state == S_RECV);
  assign mem_wen    = r_mem_wen;
  assign mem_add    = r_mem_add;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
